// File: rtl/serial_bit_sampler.sv
// Oversampling start/stop serial receiver front-end: recovers data bits LSB first
// and strobes them into a downstream shift register, flagging frame completion.
module serial_bit_sampler #(
    parameter int M   = 5,
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic bit_out,
    output logic shift,
    output logic frame_valid,
    output logic frame_err,
    output logic busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(M - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic            sync1_q, sync2_q;
    logic            bit_out_q, bit_out_d;
    logic            shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    // Synchroniser flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            bit_out_q <= 1'b0;
            shift_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            bit_out_q <= bit_out_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Strobes are registered, so each appears the cycle after its sampling instant.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        bit_out_d = bit_out_q;
        shift_d   = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_out_d = rx_s;
                    shift_d   = 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // A held-low line (break) must not be mistaken for a new start bit.
            ERR: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    assign bit_out     = bit_out_q;
    assign shift       = shift_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bit_sampler.sv
// Directed bench: DUT A at DIV=16/M=5, DUT B at DIV=4/M=8, with monitors logging strobes.
module tb_serial_bit_sampler;

    logic clk;
    logic reset;
    logic rxA, rxB;
    logic bitA, shiftA, validA, errA, busyA;
    logic bitB, shiftB, validB, errB, busyB;

    int testsRun;
    int testsFailed;
    int cyc;

    int   shiftTA[$];
    logic bitsA[$];
    int   validTA[$];
    int   errTA[$];
    int   busyTA[$];
    int   overlapA[$];
    int   shiftTB[$];
    logic bitsB[$];
    int   validTB[$];
    int   errTB[$];

    serial_bit_sampler #(.M(5), .DIV(16)) dutA (
        .clk(clk), .reset(reset), .rx(rxA),
        .bit_out(bitA), .shift(shiftA), .frame_valid(validA),
        .frame_err(errA), .busy(busyA)
    );

    serial_bit_sampler #(.M(8), .DIV(4)) dutB (
        .clk(clk), .reset(reset), .rx(rxB),
        .bit_out(bitB), .shift(shiftB), .frame_valid(validB),
        .frame_err(errB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe both DUTs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (shiftA) begin
            shiftTA.push_back(cyc);
            bitsA.push_back(bitA);
        end
        if (validA) validTA.push_back(cyc);
        if (errA) errTA.push_back(cyc);
        if (busyA) busyTA.push_back(cyc);
        if ((32'(shiftA) + 32'(validA) + 32'(errA)) > 1) overlapA.push_back(cyc);
        if (shiftB) begin
            shiftTB.push_back(cyc);
            bitsB.push_back(bitB);
        end
        if (validB) validTB.push_back(cyc);
        if (errB) errTB.push_back(cyc);
    end

    task automatic clearMon();
        shiftTA.delete(); bitsA.delete(); validTA.delete(); errTA.delete();
        busyTA.delete(); overlapA.delete();
        shiftTB.delete(); bitsB.delete(); validTB.delete(); errTB.delete();
    endtask

    task automatic holdLine(input int sel, input logic v, input int n);
        if (sel == 0) rxA = v;
        else rxB = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input int sel, input logic [7:0] d, input int nb,
                             input int div, input logic stopBit);
        holdLine(sel, 1'b0, div);
        for (int i = 0; i < nb; i++) holdLine(sel, d[i], div);
        holdLine(sel, stopBit, div);
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Rebuild the attached shift register from the logged LSB-first bits.
    function automatic logic [7:0] assemble(input int nb, input int sel);
        logic [7:0] sr;
        int n;
        sr = '0;
        n = (sel == 0) ? bitsA.size() : bitsB.size();
        for (int i = 0; i < n; i++) begin
            sr = {((sel == 0) ? bitsA[i] : bitsB[i]), sr[7:1]};
        end
        return sr >> (8 - nb);
    endfunction

    task automatic checkBits(input string name, input logic [7:0] d, input int nb,
                             input int sel, input int div);
        int n;
        n = (sel == 0) ? shiftTA.size() : shiftTB.size();
        checkCount({name, " shift count"}, n, nb);
        for (int i = 0; i < n && i < nb; i++) begin
            testsRun++;
            if (((sel == 0) ? bitsA[i] : bitsB[i]) !== d[i]) begin
                testsFailed++;
                $display("[TB] FAIL %s bit%0d: got %b, expected %b", name, i,
                         (sel == 0) ? bitsA[i] : bitsB[i], d[i]);
            end
            if (i > 0) begin
                checkCount({name, " shift spacing"},
                           (sel == 0) ? shiftTA[i] - shiftTA[i-1] : shiftTB[i] - shiftTB[i-1],
                           div);
            end
        end
        testsRun++;
        if (assemble(nb, sel) !== (d & 8'((1 << nb) - 1))) begin
            testsFailed++;
            $display("[TB] FAIL %s word: got %h, expected %h", name, assemble(nb, sel),
                     d & 8'((1 << nb) - 1));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxA = 1'b1;
        rxB = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount("reset bit_out", 32'(bitA), 0);
        checkCount("reset shift", 32'(shiftA), 0);
        checkCount("reset frame_valid", 32'(validA), 0);
        checkCount("reset frame_err", 32'(errA), 0);
        checkCount("reset busy", 32'(busyA), 0);
        checkCount("reset busy B", 32'(busyB), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        clearMon();
        sendFrame(0, 8'b10110, 5, 16, 1'b1);
        holdLine(0, 1'b1, 20);
        checkBits("nominal", 8'b10110, 5, 0, 16);
        checkCount("nominal valid count", validTA.size(), 1);
        checkCount("nominal err count", errTA.size(), 0);
        if (validTA.size() == 1 && shiftTA.size() == 5)
            checkCount("nominal latency", validTA[0] - shiftTA[4], 16);
        checkCount("nominal overlap", overlapA.size(), 0);
        @(negedge clk);
        checkCount("nominal busy idle", 32'(busyA), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_false_start();
        clearMon();
        holdLine(0, 1'b0, 4);
        holdLine(0, 1'b1, 30);
        checkCount("false start shifts", shiftTA.size(), 0);
        checkCount("false start valid", validTA.size(), 0);
        checkCount("false start err", errTA.size(), 0);
        checkCount("false start busy cycles", busyTA.size(), 8);
        checkCount("false start busy end", 32'(busyA), 0);
    endtask

    task automatic test_framing_error();
        clearMon();
        sendFrame(0, 8'b01011, 5, 16, 1'b0);
        holdLine(0, 1'b0, 40);
        checkBits("ferr", 8'b01011, 5, 0, 16);
        checkCount("ferr err count", errTA.size(), 1);
        checkCount("ferr valid count", validTA.size(), 0);
        @(negedge clk);
        checkCount("ferr busy while low", 32'(busyA), 1);
        @(posedge clk);
        #1;
        holdLine(0, 1'b1, 6);
        @(negedge clk);
        checkCount("ferr busy after release", 32'(busyA), 0);
        @(posedge clk);
        #1;
        clearMon();
        sendFrame(0, 8'b11100, 5, 16, 1'b1);
        holdLine(0, 1'b1, 20);
        checkBits("ferr recovery", 8'b11100, 5, 0, 16);
        checkCount("ferr recovery valid", validTA.size(), 1);
        checkCount("ferr recovery err", errTA.size(), 0);
    endtask

    task automatic test_reset_midframe();
        clearMon();
        holdLine(0, 1'b0, 16);
        holdLine(0, 1'b1, 16);
        holdLine(0, 1'b1, 16);
        holdLine(0, 1'b0, 8);
        checkCount("midreset shifts before", shiftTA.size(), 2);
        reset = 1'b0;
        rxA = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkCount("midreset bit_out", 32'(bitA), 0);
        checkCount("midreset shift", 32'(shiftA), 0);
        checkCount("midreset valid", 32'(validA), 0);
        checkCount("midreset err", 32'(errA), 0);
        checkCount("midreset busy", 32'(busyA), 0);
        clearMon();
        @(posedge clk);
        #1;
        holdLine(0, 1'b1, 40);
        checkCount("midreset no shifts", shiftTA.size(), 0);
        checkCount("midreset no valid", validTA.size(), 0);
        sendFrame(0, 8'b00001, 5, 16, 1'b1);
        holdLine(0, 1'b1, 20);
        checkBits("midreset next", 8'b00001, 5, 0, 16);
        checkCount("midreset next valid", validTA.size(), 1);
    endtask

    task automatic test_back_to_back();
        clearMon();
        sendFrame(0, 8'b11111, 5, 16, 1'b1);
        sendFrame(0, 8'b00000, 5, 16, 1'b1);
        holdLine(0, 1'b1, 30);
        checkCount("b2b shift count", shiftTA.size(), 10);
        for (int i = 0; i < shiftTA.size() && i < 10; i++) begin
            testsRun++;
            if (bitsA[i] !== ((i < 5) ? 1'b1 : 1'b0)) begin
                testsFailed++;
                $display("[TB] FAIL b2b bit%0d: got %b, expected %b", i, bitsA[i], (i < 5));
            end
        end
        checkCount("b2b valid count", validTA.size(), 2);
        if (validTA.size() == 2)
            checkCount("b2b valid spacing", validTA[1] - validTA[0], 112);
        checkCount("b2b err count", errTA.size(), 0);
        checkCount("b2b overlap", overlapA.size(), 0);
    endtask

    task automatic test_param_sweep();
        clearMon();
        sendFrame(1, 8'hA5, 8, 4, 1'b1);
        holdLine(1, 1'b1, 20);
        checkBits("sweep", 8'hA5, 8, 1, 4);
        checkCount("sweep valid count", validTB.size(), 1);
        checkCount("sweep err count", errTB.size(), 0);
        if (validTB.size() == 1 && shiftTB.size() == 8)
            checkCount("sweep latency", validTB[0] - shiftTB[7], 4);
        checkCount("sweep busy end", 32'(busyB), 0);
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_nominal();
        test_false_start();
        test_framing_error();
        test_reset_midframe();
        test_back_to_back();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
